rx_decode_ctrl: RTL and testbench
=================================

# rx_decode_ctrl

Sequencer for the router's receive path. Accepts one 55-bit frame at a time from the serial receiver, holds it stable for the combinational frame decoder, and samples the decoder's verdict. It then delivers local data to the node, forwards transit traffic and tokens, and requests ACK/NACK responses from the transmitter. Sits between the RX deserializer, the frame decoder, the node interface and the TX scheduler.

## Interface
- NODE_ADDR, 4'h0: this router's node address.
- DELIVER_TIMEOUT, 255: cycles to wait for node_rdy before NACKing; 8-bit range, minimum 1.
- clk in 1: sole clock, rising edge.
- rst_n in 1: asynchronous, active-low reset.
- rx_frame_vld in 1: receiver has a complete frame.
- rx_frame in 55: received frame.
- rx_rdy out 1: controller can accept a frame (IDLE only).
- dec_frame out 55: registered frame driven to the decoder.
- dec_addr in 4, dec_type in 3, dec_payload in 24, dec_bad in 1: decoder results for dec_frame.
- node_vld out 1, node_data out 24, node_rdy in 1: node delivery handshake.
- tx_req out 1, tx_kind out 2, tx_frame out 55, tx_ack in 1: transmit request; tx_kind is ACK, NACK or FWD.
- token_held out 1, token_release in 1: this node owns the token.
- ack_rcvd out 1, nack_rcvd out 1: one-cycle pulses on a received ACK or NACK frame.
- err_cnt out 8: saturating count of bad decodes.

## Operation
States: IDLE, DECODE, DELIVER, RESPOND, FORWARD, TOKEN.

**IDLE**
- rx_rdy=1.
- On rx_frame_vld, latch rx_frame into dec_frame and go to DECODE.

**DECODE** (exactly one cycle; decoder settles on the registered frame). Checks apply in this priority order:
1. dec_bad=1: increment err_cnt, set tx_kind=NACK, go to RESPOND.
2. dec_type=TOKEN: go to TOKEN.
3. dec_type=ACK or NACK: pulse ack_rcvd or nack_rcvd this cycle, go to IDLE.
4. Data type (DATA_CHK or DATA_36) with dec_addr==NODE_ADDR: latch dec_payload into node_data, go to DELIVER.
5. Data type with any other address: go to FORWARD.
6. Reserved dec_type: treated as bad (rule 1).

**DELIVER**
- node_vld=1; node_data holds steady.
- node_vld & node_rdy: tx_kind=ACK, go to RESPOND.
- Timeout counter reaches DELIVER_TIMEOUT first: drop node_vld, tx_kind=NACK, go to RESPOND.
- node_rdy arriving in the same cycle as the timeout is accepted and ACKed.

**RESPOND**
- tx_req=1; tx_kind and tx_frame hold; tx_frame = dec_frame.
- On tx_ack, go to IDLE.

**FORWARD**
- tx_req=1, tx_kind=FWD, tx_frame=dec_frame.
- On tx_ack, go to IDLE.

**TOKEN**
- token_held=1.
- On token_release, go to FORWARD, which passes the token frame on.

## Timing
- Reset values: state=IDLE, dec_frame=0, node_data=0, tx_frame=0, tx_kind=ACK, err_cnt=0. All other outputs are 0, except rx_rdy=1.
- Outputs are registered or decoded from state only; no combinational path from any input to any output.
- Latency:
  - Frame accept to node_vld: 2 cycles.
  - Frame accept to tx_req for a bad frame: 2 cycles.
  - tx_ack to rx_rdy: 1 cycle.
- Handshake rules:
  - node_vld and tx_req stay high until their acknowledge, with data held stable.
  - tx_ack while tx_req=0 is ignored.
  - token_release outside TOKEN is ignored.
- Back-to-back frames: rx_frame_vld held high is accepted again the cycle rx_rdy returns.
- Timeout counter clears on DELIVER entry and counts every DELIVER cycle.
- err_cnt saturates at 8'hFF; no wrap.
- Reset asserted mid-operation immediately returns to IDLE and clears all outputs. No partial response is sent after reset.

## Configuration
- RX_ERR_CNT_EN defined: err_cnt counts bad decodes as specified.
- RX_ERR_CNT_EN undefined: counter logic is absent and err_cnt is tied to 8'h00; all other behaviour is unchanged.

## Structure
- Shared package router_pkg holds:
  - Frame width 55 and payload width 24.
  - Type codes: TOKEN=3'b000, ACK=3'b001, NACK=3'b010, DATA_CHK=3'b011, DATA_36=3'b100; others reserved.
  - tx_kind codes: ACK=2'b00, NACK=2'b01, FWD=2'b10.
  - State enum.
- One sub-module, decode_timeout_cnt: 8-bit counter with clear, enable and a terminal-count output, parameterised by DELIVER_TIMEOUT.

## Test plan
- Local data: good DATA_CHK frame, addr=NODE_ADDR, payload 24'hABCDEF, node_rdy tied high -> node_vld two cycles after accept with node_data=24'hABCDEF. Then tx_req with tx_kind=ACK; tx_ack returns rx_rdy=1 one cycle later.
- Bad decode: dec_bad=1 on a DATA_36 frame -> no node_vld, tx_req with tx_kind=NACK, err_cnt 0->1. After 300 bad frames err_cnt=8'hFF (with the macro defined).
- Node timeout: DELIVER_TIMEOUT=4, node_rdy held low -> node_vld drops after 4 cycles, then tx_kind=NACK. A second run with node_rdy high on the timeout cycle -> ACK.
- Transit and token: data frame with addr=4'h5 and NODE_ADDR=0 -> tx_kind=FWD with tx_frame equal to the received frame. TOKEN frame -> token_held=1 until token_release, then FWD.
- ACK/NACK receipt and reset: ACK frame -> ack_rcvd pulses for one cycle, no tx_req. rst_n pulsed low during RESPOND -> tx_req=0 and rx_rdy=1 asynchronously; no stale request after release.

Source files
------------

// File: rtl/router_pkg.sv
// Shared receive-path types: frame geometry, frame type codes, TX request kinds
// and the rx_decode_ctrl state encoding.
package router_pkg;

    localparam int FRAME_W   = 55;
    localparam int PAYLOAD_W = 24;

    localparam logic [2:0] TYPE_TOKEN    = 3'b000;
    localparam logic [2:0] TYPE_ACK      = 3'b001;
    localparam logic [2:0] TYPE_NACK     = 3'b010;
    localparam logic [2:0] TYPE_DATA_CHK = 3'b011;
    localparam logic [2:0] TYPE_DATA_36  = 3'b100;

    typedef enum logic [1:0] {
        TX_ACK  = 2'b00,
        TX_NACK = 2'b01,
        TX_FWD  = 2'b10
    } tx_kind_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_DELIVER,
        S_RESPOND,
        S_FORWARD,
        S_TOKEN
    } state_e;

    // Codes above DATA_36 are unassigned and must be NACKed like a bad decode.
    function automatic logic type_reserved(input logic [2:0] t);
        return t > TYPE_DATA_36;
    endfunction

endpackage

// File: rtl/decode_timeout_cnt.sv
// Delivery wait counter: cleared on DELIVER entry, counts enabled cycles and
// flags the DELIVER_TIMEOUT-th enabled cycle.
module decode_timeout_cnt #(
    parameter int unsigned DELIVER_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [7:0] TC_VAL = 8'(DELIVER_TIMEOUT - 1);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en && cnt_q != 8'hFF)
            cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    // cnt_q holds the number of DELIVER cycles already completed.
    assign tc = en && (cnt_q == TC_VAL);

endmodule

// File: rtl/rx_decode_ctrl.sv
// Receive-path sequencer: holds a frame for the decoder, then delivers, forwards,
// holds the token or requests ACK/NACK. RX_ERR_CNT_EN enables the bad-decode counter.
module rx_decode_ctrl
    import router_pkg::*;
#(
    parameter logic [3:0]  NODE_ADDR       = 4'h0,
    parameter int unsigned DELIVER_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_frame_vld,
    input  logic [FRAME_W-1:0]   rx_frame,
    output logic                 rx_rdy,
    output logic [FRAME_W-1:0]   dec_frame,
    input  logic [3:0]           dec_addr,
    input  logic [2:0]           dec_type,
    input  logic [PAYLOAD_W-1:0] dec_payload,
    input  logic                 dec_bad,
    output logic                 node_vld,
    output logic [PAYLOAD_W-1:0] node_data,
    input  logic                 node_rdy,
    output logic                 tx_req,
    output logic [1:0]           tx_kind,
    output logic [FRAME_W-1:0]   tx_frame,
    input  logic                 tx_ack,
    output logic                 token_held,
    input  logic                 token_release,
    output logic                 ack_rcvd,
    output logic                 nack_rcvd,
    output logic [7:0]           err_cnt
);

    state_e                 state_q, state_d;
    logic [FRAME_W-1:0]     dec_frame_q, dec_frame_d;
    logic [PAYLOAD_W-1:0]   node_data_q, node_data_d;
    tx_kind_e               tx_kind_q, tx_kind_d;
    logic                   ack_rcvd_q, ack_rcvd_d;
    logic                   nack_rcvd_q, nack_rcvd_d;
    logic                   cnt_clr, cnt_en, cnt_tc;
`ifdef RX_ERR_CNT_EN
    logic [7:0]             err_cnt_q, err_cnt_d;
`endif

    decode_timeout_cnt #(.DELIVER_TIMEOUT(DELIVER_TIMEOUT)) u_timeout (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .tc    (cnt_tc)
    );

    always_comb begin
        state_d     = state_q;
        dec_frame_d = dec_frame_q;
        node_data_d = node_data_q;
        tx_kind_d   = tx_kind_q;
        ack_rcvd_d  = 1'b0;
        nack_rcvd_d = 1'b0;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
`ifdef RX_ERR_CNT_EN
        err_cnt_d   = err_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (rx_frame_vld) begin
                    dec_frame_d = rx_frame;
                    state_d     = S_DECODE;
                end
            end
            S_DECODE: begin
                cnt_clr = 1'b1;
                if (dec_bad || type_reserved(dec_type)) begin
`ifdef RX_ERR_CNT_EN
                    if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
`endif
                    tx_kind_d = TX_NACK;
                    state_d   = S_RESPOND;
                end else if (dec_type == TYPE_TOKEN) begin
                    state_d = S_TOKEN;
                end else if (dec_type == TYPE_ACK) begin
                    ack_rcvd_d = 1'b1;
                    state_d    = S_IDLE;
                end else if (dec_type == TYPE_NACK) begin
                    nack_rcvd_d = 1'b1;
                    state_d     = S_IDLE;
                end else if (dec_addr == NODE_ADDR) begin
                    node_data_d = dec_payload;
                    state_d     = S_DELIVER;
                end else begin
                    tx_kind_d = TX_FWD;
                    state_d   = S_FORWARD;
                end
            end
            S_DELIVER: begin
                cnt_en = 1'b1;
                // A node_rdy landing on the timeout cycle still wins.
                if (node_rdy) begin
                    tx_kind_d = TX_ACK;
                    state_d   = S_RESPOND;
                end else if (cnt_tc) begin
                    tx_kind_d = TX_NACK;
                    state_d   = S_RESPOND;
                end
            end
            S_RESPOND, S_FORWARD: begin
                if (tx_ack) state_d = S_IDLE;
            end
            S_TOKEN: begin
                if (token_release) begin
                    tx_kind_d = TX_FWD;
                    state_d   = S_FORWARD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            dec_frame_q <= '0;
            node_data_q <= '0;
            tx_kind_q   <= TX_ACK;
            ack_rcvd_q  <= 1'b0;
            nack_rcvd_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dec_frame_q <= dec_frame_d;
            node_data_q <= node_data_d;
            tx_kind_q   <= tx_kind_d;
            ack_rcvd_q  <= ack_rcvd_d;
            nack_rcvd_q <= nack_rcvd_d;
        end
    end

`ifdef RX_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_cnt_q <= '0;
        else        err_cnt_q <= err_cnt_d;
    end
    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'h00;
`endif

    // Receipt pulses are registered, so they appear in the IDLE cycle after DECODE.
    assign rx_rdy     = (state_q == S_IDLE);
    assign node_vld   = (state_q == S_DELIVER);
    assign tx_req     = (state_q == S_RESPOND) || (state_q == S_FORWARD);
    assign token_held = (state_q == S_TOKEN);
    assign dec_frame  = dec_frame_q;
    assign tx_frame   = dec_frame_q;
    assign node_data  = node_data_q;
    assign tx_kind    = tx_kind_q;
    assign ack_rcvd   = ack_rcvd_q;
    assign nack_rcvd  = nack_rcvd_q;

endmodule

// File: tb/tb_rx_decode_ctrl.sv
// Randomized scoreboard bench for rx_decode_ctrl; a stub decoder reads fields
// straight out of dec_frame: [54:52] type, [51:48] addr, [47:24] payload, [0] bad.
module tb_rx_decode_ctrl;

    localparam logic [3:0] TB_NODE = 4'h0;
    localparam int         TB_TO   = 4;
`ifdef RX_ERR_CNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    localparam int EV_NODE = 0, EV_TX = 1, EV_TOK = 2, EV_ACKR = 3, EV_NACKR = 4;

    typedef struct {
        int          kind;
        logic [54:0] data;
        logic [1:0]  tk;
        int          len;
        int          lat;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_frame_vld;
    logic [54:0] rx_frame;
    logic        rx_rdy;
    logic [54:0] dec_frame;
    logic [3:0]  dec_addr;
    logic [2:0]  dec_type;
    logic [23:0] dec_payload;
    logic        dec_bad;
    logic        node_vld;
    logic [23:0] node_data;
    logic        node_rdy;
    logic        tx_req;
    logic [1:0]  tx_kind;
    logic [54:0] tx_frame;
    logic        tx_ack;
    logic        token_held;
    logic        token_release;
    logic        ack_rcvd, nack_rcvd;
    logic [7:0]  err_cnt;

    int   checks = 0;
    int   errors = 0;
    int   exp_err = 0;
    ev_t  q[$];

    always #5 clk = ~clk;

    assign dec_type    = dec_frame[54:52];
    assign dec_addr    = dec_frame[51:48];
    assign dec_payload = dec_frame[47:24];
    assign dec_bad     = dec_frame[0];

    rx_decode_ctrl #(.NODE_ADDR(TB_NODE), .DELIVER_TIMEOUT(TB_TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_frame_vld(rx_frame_vld), .rx_frame(rx_frame), .rx_rdy(rx_rdy),
        .dec_frame(dec_frame), .dec_addr(dec_addr), .dec_type(dec_type),
        .dec_payload(dec_payload), .dec_bad(dec_bad),
        .node_vld(node_vld), .node_data(node_data), .node_rdy(node_rdy),
        .tx_req(tx_req), .tx_kind(tx_kind), .tx_frame(tx_frame), .tx_ack(tx_ack),
        .token_held(token_held), .token_release(token_release),
        .ack_rcvd(ack_rcvd), .nack_rcvd(nack_rcvd), .err_cnt(err_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [54:0] mk(input logic [2:0] t, input logic [3:0] a,
                                       input logic [23:0] p, input logic bad);
        logic [22:0] r;
        r = 23'($urandom);
        return {t, a, p, r, bad};
    endfunction

    function automatic ev_t ev(input int kind, input logic [54:0] d, input logic [1:0] tk,
                               input int len, input int lat);
        ev_t e;
        e.kind = kind; e.data = d; e.tk = tk; e.len = len; e.lat = lat;
        return e;
    endfunction

    // Reference behaviour: what the outside world should see for one frame.
    task automatic model_push(input logic [54:0] f, input int rdy_at, input int ack_d, input int rel_d);
        logic [2:0] t;
        logic [3:0] a;
        t = f[54:52];
        a = f[51:48];
        if (f[0] || t > 3'd4) begin
            if (ERR_EN && exp_err < 255) exp_err++;
            q.push_back(ev(EV_TX, f, 2'b01, ack_d, 1));
        end else if (t == 3'd0) begin
            q.push_back(ev(EV_TOK, f, 2'b00, rel_d, 1));
            q.push_back(ev(EV_TX, f, 2'b10, ack_d, -1));
        end else if (t == 3'd1) begin
            q.push_back(ev(EV_ACKR, f, 2'b00, 1, 1));
        end else if (t == 3'd2) begin
            q.push_back(ev(EV_NACKR, f, 2'b00, 1, 1));
        end else if (a == TB_NODE) begin
            q.push_back(ev(EV_NODE, {31'd0, f[47:24]}, 2'b00, (rdy_at < TB_TO) ? rdy_at : TB_TO, 1));
            q.push_back(ev(EV_TX, f, (rdy_at <= TB_TO) ? 2'b00 : 2'b01, ack_d, -1));
        end else begin
            q.push_back(ev(EV_TX, f, 2'b10, ack_d, 1));
        end
    endtask

    task automatic send(input logic [54:0] f, input int rdy_at, input int ack_d, input int rel_d);
        int vc = 0, tc = 0, kc = 0, guard = 0;
        while (!rx_rdy && guard < 1000) begin @(negedge clk); guard++; end
        if (guard >= 1000) begin chk("rx_rdy_wait", 0, 1); return; end
        model_push(f, rdy_at, ack_d, rel_d);
        rx_frame = f;
        rx_frame_vld = 1'b1;
        @(negedge clk);
        rx_frame_vld = 1'b0;
        rx_frame = 55'($urandom);
        guard = 0;
        while (!rx_rdy && guard < 1000) begin
            if (node_vld) vc++;
            node_rdy = node_vld ? (vc >= rdy_at) : 1'($urandom);
            if (tx_req) tc++;
            tx_ack = tx_req ? (tc >= ack_d) : 1'($urandom);
            if (token_held) kc++;
            token_release = token_held ? (kc >= rel_d) : 1'($urandom);
            @(negedge clk);
            guard++;
        end
        node_rdy = 1'b0; tx_ack = 1'b0; token_release = 1'b0;
        if (guard >= 1000) chk("txn_done_wait", 0, 1);
        chk("err_cnt", err_cnt, exp_err);
    endtask

    // Monitor: pops an expectation whenever the DUT starts presenting something.
    bit  in_node, in_tx, in_tok, prev_rdy, prev_ack, prev_nack;
    int  since, nlen, tlen, klen;
    ev_t cur_node, cur_tx, cur_tok;

    task automatic pop_ev(input int kind, output ev_t e, output bit ok);
        ok = 1'b0;
        e  = ev(-1, '0, 2'b00, 0, -1);
        if (q.size() == 0) begin
            chk("event_unexpected", 64'(kind), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
            e  = q.pop_front();
            chk("event_kind", 64'(kind), 64'(e.kind));
            ok = (kind == e.kind);
            if (ok && e.lat >= 0) chk("event_latency", 64'(since), 64'(e.lat));
        end
    endtask

    always @(negedge clk) begin
        ev_t e;
        bit  ok;
        if (!rst_n) begin
            q.delete();
            in_node = 0; in_tx = 0; in_tok = 0;
            prev_rdy = 1; prev_ack = 0; prev_nack = 0; since = 0;
        end else begin
            if (prev_rdy && !rx_rdy) since = 0; else since++;
            if (ack_rcvd || nack_rcvd) begin
                chk("ack_nack_excl", ack_rcvd & nack_rcvd, 0);
                chk("rcvd_one_cycle", (ack_rcvd & prev_ack) | (nack_rcvd & prev_nack), 0);
                pop_ev(ack_rcvd ? EV_ACKR : EV_NACKR, e, ok);
            end
            if (node_vld && !in_node) begin
                pop_ev(EV_NODE, e, ok);
                cur_node = e; in_node = 1; nlen = 1;
                chk("node_data", node_data, e.data[23:0]);
            end else if (node_vld) begin
                nlen++;
                chk("node_data_hold", node_data, cur_node.data[23:0]);
            end else if (in_node) begin
                chk("node_vld_len", 64'(nlen), 64'(cur_node.len));
                in_node = 0;
            end
            if (token_held && !in_tok) begin
                pop_ev(EV_TOK, e, ok);
                cur_tok = e; in_tok = 1; klen = 1;
            end else if (token_held) begin
                klen++;
            end else if (in_tok) begin
                chk("token_len", 64'(klen), 64'(cur_tok.len));
                in_tok = 0;
            end
            if (tx_req && !in_tx) begin
                pop_ev(EV_TX, e, ok);
                cur_tx = e; in_tx = 1; tlen = 1;
                chk("tx_kind", tx_kind, e.tk);
                chk("tx_frame", tx_frame, e.data);
            end else if (tx_req) begin
                tlen++;
                chk("tx_hold", {tx_kind, tx_frame}, {cur_tx.tk, cur_tx.data});
            end else if (in_tx) begin
                chk("tx_req_len", 64'(tlen), 64'(cur_tx.len));
                chk("rx_rdy_after_ack", rx_rdy, 1);
                in_tx = 0;
            end
            prev_rdy  = rx_rdy;
            prev_ack  = ack_rcvd;
            prev_nack = nack_rcvd;
        end
    end

    initial begin
        logic [54:0] f;
        int guard;
        rst_n = 1'b0;
        rx_frame_vld = 1'b0; rx_frame = '0;
        node_rdy = 1'b0; tx_ack = 1'b0; token_release = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rx_rdy", rx_rdy, 1);
        chk("rst_node_vld", node_vld, 0);
        chk("rst_tx_req", tx_req, 0);
        chk("rst_tx_kind", tx_kind, 0);
        chk("rst_frames", {dec_frame, tx_frame, node_data}, 0);
        chk("rst_misc", {token_held, ack_rcvd, nack_rcvd, err_cnt}, 0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        send(mk(3'd3, TB_NODE, 24'hABCDEF, 1'b0), 1, 1, 1);   // local DATA_CHK, ACK
        send(mk(3'd4, TB_NODE, 24'h123456, 1'b1), 1, 2, 1);   // bad DATA_36, NACK
        send(mk(3'd3, TB_NODE, 24'h000111, 1'b0), 10, 1, 1);  // timeout -> NACK
        send(mk(3'd4, TB_NODE, 24'h000222, 1'b0), TB_TO, 1, 1); // rdy on timeout cycle
        send(mk(3'd3, TB_NODE, 24'h000333, 1'b0), 3, 2, 1);
        send(mk(3'd3, 4'h5, 24'h555555, 1'b0), 1, 3, 1);      // transit FWD
        send(mk(3'd0, 4'h9, 24'h0, 1'b0), 1, 1, 3);           // token, then FWD
        send(mk(3'd1, TB_NODE, 24'h0, 1'b0), 1, 1, 1);        // ACK received
        send(mk(3'd2, TB_NODE, 24'h0, 1'b0), 1, 1, 1);        // NACK received
        send(mk(3'd7, TB_NODE, 24'h0, 1'b0), 1, 1, 1);        // reserved type
        send(mk(3'd5, 4'h3, 24'h0, 1'b0), 1, 2, 1);

        for (int i = 0; i < 150; i++) begin
            logic [3:0] a;
            a = ($urandom_range(0, 1) == 0) ? TB_NODE : 4'($urandom_range(0, 15));
            send(mk(3'($urandom_range(0, 7)), a, 24'($urandom), $urandom_range(0, 7) == 0),
                 $urandom_range(1, 7), $urandom_range(1, 4), $urandom_range(1, 4));
        end

        for (int i = 0; i < 300; i++)
            send(mk(3'($urandom_range(3, 4)), TB_NODE, 24'($urandom), 1'b1), 1, 1, 1);
        chk("err_cnt_saturated", err_cnt, ERR_EN ? 8'hFF : 8'h00);

        // Reset while a NACK request is outstanding.
        f = mk(3'd4, TB_NODE, 24'h0, 1'b1);
        model_push(f, 1, 1000, 1);
        rx_frame = f; rx_frame_vld = 1'b1;
        @(negedge clk);
        rx_frame_vld = 1'b0;
        guard = 0;
        while (!tx_req && guard < 20) begin @(negedge clk); guard++; end
        chk("respond_reached", tx_req, 1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_tx_req", tx_req, 0);
        chk("async_rst_rx_rdy", rx_rdy, 1);
        chk("async_rst_out", {tx_frame, tx_kind, err_cnt}, 0);
        exp_err = 0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("no_stale_req", {tx_req, rx_rdy}, 2'b01);
        end
        send(mk(3'd3, TB_NODE, 24'hFEDCBA, 1'b0), 2, 1, 1);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 64'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "global timeout");
    end

endmodule
